vpu_operand_fetch_unit: RTL and testbench

Read-side counterpart of the VPU write-back path. On a start pulse from the VPU controller it fetches 1–3 source operand words from the scratchpad SRAM through the VPU source read port, one request/ack handshake per operand, and buffers them. It then streams them to the VPU lane as EXEC_CNT slices of DWIDTH_PER_EXEC bits each, under a valid/ready handshake. It sits between the SRAM read port and the VPU_LANE input, and reports idle to the controller through `done_o`.

---
 rtl/vpu_operand_fetch_unit_if.sv | 37 +++
 rtl/vpu_operand_fetch_unit.sv | 97 +++++++++
 tb/tb_vpu_operand_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vpu_operand_fetch_unit_if.sv
// vpu_operand_fetch_unit_if: controller, SRAM read-port and lane-stream signals of the operand fetch unit
//   start_i/done_o/src_cnt_i/src_addr_i : controller side
//   rd_req_o/rd_rid_o/rd_addr_o/rd_ack_i/rd_rvalid_i/rd_rdata_i : SRAM source read port
//   op_valid_o/op_ready_i/op_data_o/op_last_o : slice stream to the VPU lane
//   slave modport is the fetch unit, master modport is its environment
interface vpu_operand_fetch_unit_if #(
  parameter int SRAM_DATA_WIDTH = 512,
  parameter int EXEC_CNT = 4,
  parameter int DWIDTH_PER_EXEC = SRAM_DATA_WIDTH / EXEC_CNT,
  parameter int SRAM_BANK_CNT_LG2 = 2,
  parameter int SRAM_BANK_DEPTH_LG2 = 10,
  parameter int MAX_SRC = 3,
  parameter int ADDR_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2
) ();
  logic start_i;
  logic done_o;
  logic [1:0] src_cnt_i;
  logic [MAX_SRC*ADDR_W-1:0] src_addr_i;
  logic rd_req_o;
  logic [SRAM_BANK_CNT_LG2-1:0] rd_rid_o;
  logic [SRAM_BANK_DEPTH_LG2-1:0] rd_addr_o;
  logic rd_ack_i;
  logic rd_rvalid_i;
  logic [SRAM_DATA_WIDTH-1:0] rd_rdata_i;
  logic op_valid_o;
  logic op_ready_i;
  logic [MAX_SRC*DWIDTH_PER_EXEC-1:0] op_data_o;
  logic op_last_o;
  modport slave (
    input start_i, src_cnt_i, src_addr_i, rd_ack_i, rd_rvalid_i, rd_rdata_i, op_ready_i,
    output done_o, rd_req_o, rd_rid_o, rd_addr_o, op_valid_o, op_data_o, op_last_o
  );
  modport master (
    output start_i, src_cnt_i, src_addr_i, rd_ack_i, rd_rvalid_i, rd_rdata_i, op_ready_i,
    input done_o, rd_req_o, rd_rid_o, rd_addr_o, op_valid_o, op_data_o, op_last_o
  );
endinterface

// File: rtl/vpu_operand_fetch_unit.sv
// vpu_operand_fetch_unit: fetches 1-3 SRAM operand words and streams them to the VPU lane as slices
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of vpu_operand_fetch_unit_if (controller, SRAM read port, lane stream)
module vpu_operand_fetch_unit #(
  parameter int SRAM_DATA_WIDTH = 512,
  parameter int EXEC_CNT = 4,
  parameter int DWIDTH_PER_EXEC = SRAM_DATA_WIDTH / EXEC_CNT,
  parameter int SRAM_BANK_CNT_LG2 = 2,
  parameter int SRAM_BANK_DEPTH_LG2 = 10,
  parameter int MAX_SRC = 3,
  parameter int ADDR_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2
) (
  input logic clk,
  input logic rst_n,
  vpu_operand_fetch_unit_if.slave bus
);
  localparam int SW = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;
  state_t state_q, state_d;
  logic [1:0] k_q, k_d, cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic [MAX_SRC*ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0] buf_q [MAX_SRC];
  logic [SRAM_DATA_WIDTH-1:0] buf_d [MAX_SRC];
  logic [ADDR_W-1:0] req_addr;
  logic [MAX_SRC*DWIDTH_PER_EXEC-1:0] data_d;
  logic last_beat, last_op;
  assign last_beat = s_q == SW'(EXEC_CNT - 1);
  assign last_op = 2'(k_q + 2'd1) == cnt_q;
  assign bus.done_o = state_q == IDLE;
  assign req_addr = addr_d[k_d*ADDR_W +: ADDR_W];
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    s_d = s_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = REQ;
        k_d = '0;
        cnt_d = (bus.src_cnt_i == 2'd0) ? 2'd1 : bus.src_cnt_i;
        addr_d = bus.src_addr_i;
      end
      REQ: if (bus.rd_req_o && bus.rd_ack_i) state_d = WAIT;
      WAIT: if (bus.rd_rvalid_i) begin
        buf_d[k_q] = bus.rd_rdata_i;
        state_d = last_op ? STREAM : REQ;
        k_d = last_op ? k_q : k_q + 2'd1;
        s_d = '0;
      end
      STREAM: if (bus.op_valid_o && bus.op_ready_i) begin
        state_d = last_beat ? IDLE : STREAM;
        s_d = last_beat ? '0 : s_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Output slices are built from next-cycle state so the word captured on the
  // final rvalid is already visible on the first beat.
  always_comb begin
    data_d = '0;
    for (int j = 0; j < MAX_SRC; j++)
      if (state_d == STREAM && j < int'(cnt_d))
        data_d[j*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = buf_d[j][s_d*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      s_q <= '0;
      cnt_q <= 2'd1;
      addr_q <= '0;
      buf_q <= '{default: '0};
      bus.rd_req_o <= 1'b0;
      bus.rd_rid_o <= '0;
      bus.rd_addr_o <= '0;
      bus.op_valid_o <= 1'b0;
      bus.op_last_o <= 1'b0;
      bus.op_data_o <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      buf_q <= buf_d;
      bus.rd_req_o <= state_d == REQ;
      bus.rd_rid_o <= (state_d == REQ) ? req_addr[ADDR_W-1 -: SRAM_BANK_CNT_LG2] : '0;
      bus.rd_addr_o <= (state_d == REQ) ? req_addr[SRAM_BANK_DEPTH_LG2-1:0] : '0;
      bus.op_valid_o <= state_d == STREAM;
      bus.op_last_o <= state_d == STREAM && s_d == SW'(EXEC_CNT - 1);
      bus.op_data_o <= data_d;
    end
  end
endmodule

// File: tb/tb_vpu_operand_fetch_unit.sv
// tb_vpu_operand_fetch_unit: directed self-checking bench for the operand fetch unit
module tb_vpu_operand_fetch_unit;
  localparam int DW = 128;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs = 0;
  int t0;
  logic [511:0] wa, wb, wc;
  vpu_operand_fetch_unit_if bus ();
  vpu_operand_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.op_valid_o && bus.op_ready_i) hs <= hs + 1;
  end
  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic logic [511:0] mkword(input logic [31:0] base);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = base + 32'(i);
    return w;
  endfunction
  function automatic logic [3*DW-1:0] exp_beat(input logic [511:0] w0, w1, w2, input logic [1:0] cnt, input int b);
    logic [511:0] w [3];
    logic [3*DW-1:0] r;
    int c;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    c = (cnt == 2'd0) ? 1 : int'(cnt);
    r = '0;
    for (int j = 0; j < c; j++) r[j*DW +: DW] = w[j][b*DW +: DW];
    return r;
  endfunction
  task automatic launch(input logic [1:0] cnt, input logic [AW-1:0] a0, a1, a2, output int t);
    bus.src_cnt_i = cnt;
    bus.src_addr_i = {a2, a1, a0};
    bus.start_i = 1'b1;
    t = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.src_cnt_i = 2'd2;
    bus.src_addr_i = '1;
    check("busy", bus.done_o, 1'b0);
  endtask
  task automatic serve(input logic [1:0] rid, input logic [9:0] addr, input int dly, input logic [511:0] w,
                       input bit stray, input bit pulse);
    check("req", bus.rd_req_o, 1'b1);
    check("rid", bus.rd_rid_o, rid);
    check("addr", bus.rd_addr_o, addr);
    for (int i = 0; i < dly; i++) begin
      bus.rd_ack_i = 1'b0;
      bus.rd_rvalid_i = stray && i == 0;
      bus.rd_rdata_i = stray ? ~w : '0;
      @(negedge clk);
      check("req_hold", bus.rd_req_o, 1'b1);
      check("rid_hold", bus.rd_rid_o, rid);
      check("addr_hold", bus.rd_addr_o, addr);
    end
    bus.rd_rvalid_i = 1'b0;
    bus.rd_rdata_i = '0;
    bus.rd_ack_i = 1'b1;
    @(negedge clk);
    bus.rd_ack_i = 1'b0;
    check("req_drop", bus.rd_req_o, 1'b0);
    check("rid_zero", bus.rd_rid_o, 2'd0);
    check("addr_zero", bus.rd_addr_o, 10'd0);
    bus.rd_rvalid_i = 1'b1;
    bus.rd_rdata_i = w;
    bus.start_i = pulse;
    @(negedge clk);
    bus.rd_rvalid_i = 1'b0;
    bus.rd_rdata_i = '0;
    bus.start_i = 1'b0;
  endtask
  task automatic stream(input logic [511:0] w0, w1, w2, input logic [1:0] cnt, input logic [3:0] stall, input bit pulse);
    int h0;
    logic [3*DW-1:0] e;
    h0 = hs;
    for (int b = 0; b < 4; b++) begin
      e = exp_beat(w0, w1, w2, cnt, b);
      check("valid", bus.op_valid_o, 1'b1);
      check("data", bus.op_data_o, e);
      check("last", bus.op_last_o, b == 3);
      if (stall[b]) begin
        bus.op_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check("valid_stall", bus.op_valid_o, 1'b1);
          check("data_stall", bus.op_data_o, e);
          check("last_stall", bus.op_last_o, b == 3);
        end
      end
      bus.op_ready_i = 1'b1;
      bus.start_i = pulse && b == 0;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    bus.op_ready_i = 1'b0;
    check("valid_end", bus.op_valid_o, 1'b0);
    check("last_end", bus.op_last_o, 1'b0);
    check("data_end", bus.op_data_o, '0);
    check("done_end", bus.done_o, 1'b1);
    check("no_req", bus.rd_req_o, 1'b0);
    check("handshakes", hs - h0, 4);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.src_cnt_i = '0;
    bus.src_addr_i = '0;
    bus.rd_ack_i = 1'b0;
    bus.rd_rvalid_i = 1'b0;
    bus.rd_rdata_i = '0;
    bus.op_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", bus.done_o, 1'b1);
    check("rst_req", bus.rd_req_o, 1'b0);
    check("rst_rid", bus.rd_rid_o, 2'd0);
    check("rst_addr", bus.rd_addr_o, 10'd0);
    check("rst_valid", bus.op_valid_o, 1'b0);
    check("rst_last", bus.op_last_o, 1'b0);
    check("rst_data", bus.op_data_o, '0);
    rst_n = 1'b1;
    @(negedge clk);
    wa = mkword(32'h1000_0000);
    launch(2'd1, {2'd1, 10'd5}, '0, '0, t0);
    serve(2'd1, 10'd5, 0, wa, 1'b0, 1'b0);
    stream(wa, '0, '0, 2'd1, 4'b0000, 1'b0);
    check("latency", cyc - t0, 7);
    wa = mkword(32'hA000_0000);
    wb = mkword(32'hB000_0000);
    wc = mkword(32'hC000_0000);
    launch(2'd3, {2'd0, 10'd17}, {2'd2, 10'd300}, {2'd3, 10'd1023}, t0);
    serve(2'd0, 10'd17, 3, wa, 1'b1, 1'b0);
    serve(2'd2, 10'd300, 3, wb, 1'b0, 1'b1);
    serve(2'd3, 10'd1023, 3, wc, 1'b0, 1'b0);
    stream(wa, wb, wc, 2'd3, 4'b1010, 1'b1);
    wa = mkword(32'hD000_0000);
    launch(2'd0, {2'd3, 10'd77}, '0, '0, t0);
    serve(2'd3, 10'd77, 0, wa, 1'b0, 1'b0);
    stream(wa, '0, '0, 2'd0, 4'b0000, 1'b0);
    wa = mkword(32'hE000_0000);
    wb = mkword(32'hF000_0000);
    launch(2'd2, {2'd0, 10'd1}, {2'd1, 10'd2}, '0, t0);
    serve(2'd0, 10'd1, 0, wa, 1'b0, 1'b0);
    serve(2'd1, 10'd2, 1, wb, 1'b0, 1'b0);
    check("mid_valid", bus.op_valid_o, 1'b1);
    bus.op_ready_i = 1'b1;
    @(negedge clk);
    check("mid_data", bus.op_data_o, exp_beat(wa, wb, '0, 2'd2, 1));
    rst_n = 1'b0;
    bus.op_ready_i = 1'b0;
    @(negedge clk);
    check("mrst_done", bus.done_o, 1'b1);
    check("mrst_req", bus.rd_req_o, 1'b0);
    check("mrst_valid", bus.op_valid_o, 1'b0);
    check("mrst_last", bus.op_last_o, 1'b0);
    check("mrst_data", bus.op_data_o, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_valid", bus.op_valid_o, 1'b0);
    check("post_done", bus.done_o, 1'b1);
    wa = mkword(32'h5500_0000);
    launch(2'd1, {2'd2, 10'd512}, '0, '0, t0);
    serve(2'd2, 10'd512, 2, wa, 1'b0, 1'b0);
    stream(wa, '0, '0, 2'd1, 4'b0001, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
